// File: rtl/subtractor_pkg.sv
// Shared bit-level helpers for the subtractor: per-bit difference/borrow
// equations and the two's-complement overflow rule used by the optional flags.
package subtractor_pkg;

    function automatic logic diff_bit(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Borrow out of a bit: y beats x outright, or x==y and a borrow ripples through.
    function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor
    import subtractor_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = diff_bit(x, y, bi);
    assign bo = borrow_bit(x, y, bi);

endmodule

// File: rtl/subtractor.sv
// Registered WIDTH-bit ripple subtractor (a - b - bin) with borrow-out.
// Define SUBTRACTOR_FLAGS_EN to register the zero and signed-overflow flags.
module subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_next;

    assign borrow[0] = bin;

    // Borrow chain runs LSB to MSB; the final borrow is the block's bout.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_cell (
            .x  (a[i]),
            .y  (b[i]),
            .bi (borrow[i]),
            .d  (diff_next[i]),
            .bo (borrow[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff <= diff_next;
                bout <= borrow[WIDTH];
            end
        end
    end

`ifdef SUBTRACTOR_FLAGS_EN
    logic zero_next;
    logic ovf_next;

    assign zero_next = (diff_next == '0);
    assign ovf_next  = signed_ovf(a[WIDTH-1], b[WIDTH-1], diff_next[WIDTH-1]);

    // Flags follow the same capture/hold rules as diff.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= zero_next;
            ovf  <= ovf_next;
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: directed vector table, hand-written
// back-to-back / reset sequences, and random stimulus against an arithmetic model.
module tb_subtractor;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;
`ifdef SUBTRACTOR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: what the outputs should show after the last edge.
    logic         m_valid;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_zero;
    logic         m_ovf;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic plus the MSB overflow rule.
    task automatic model_step(input logic r, input logic v, input logic [W-1:0] ai,
                              input logic [W-1:0] bi, input logic ci);
        int d;
        if (r) begin
            m_valid = 0; m_diff = 0; m_bout = 0; m_zero = 0; m_ovf = 0;
        end else begin
            m_valid = v;
            if (v) begin
                d      = (int'(ai) - int'(bi) - int'(ci)) & MASK;
                m_diff = d[W-1:0];
                m_bout = int'(ai) < (int'(bi) + int'(ci));
                m_zero = FLAGS && (d == 0);
                m_ovf  = FLAGS && (ai[W-1] != bi[W-1]) && (m_diff[W-1] != ai[W-1]);
            end
        end
    endtask

    task automatic check_output(input string name, input logic ev, input logic [W-1:0] ed,
                                input logic eb, input logic ez, input logic eo);
        checks++;
        if ({out_valid, diff, bout, zero, ovf} !== {ev, ed, eb, ez, eo}) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b diff=%b bout=%b zero=%b ovf=%b, expected valid=%b diff=%b bout=%b zero=%b ovf=%b",
                     name, out_valid, diff, bout, zero, ovf, ev, ed, eb, ez, eo);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and compare just after the edge.
    task automatic apply_stimulus(input string name, input logic r, input logic v,
                                  input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input logic ci);
        rst = r; in_valid = v; a = ai; b = bi; bin = ci;
        @(posedge clk);
        #1;
        model_step(r, v, ai, bi, ci);
        check_output(name, m_valid, m_diff, m_bout, m_zero, m_ovf);
    endtask

    initial begin
        rst = 1; in_valid = 0; a = 0; b = 0; bin = 0;
        m_valid = 0; m_diff = 0; m_bout = 0; m_zero = 0; m_ovf = 0;

        // {a, b, bin, diff, bout, zero(flags on), ovf(flags on)}
        vecs.push_back('{4'b0011, 4'b1001, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{4'b1011, 4'b0001, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'b0011, 4'b1001, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{4'b1111, 4'b0111, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b1011, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'b0110, 4'b0110, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0});

        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset_state", 0, 4'b0000, 0, 0, 0);

        rst = 0;
        foreach (vecs[i]) begin
            in_valid = 1; a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin;
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d", i), 1'b1, vecs[i].diff, vecs[i].bout,
                         FLAGS & vecs[i].zero, FLAGS & vecs[i].ovf);
            model_step(0, 1, vecs[i].a, vecs[i].b, vecs[i].bin);
        end

        // Idle cycles: outputs hold, out_valid drops.
        apply_stimulus("hold0", 0, 0, 4'b0101, 4'b1010, 1'b1);
        apply_stimulus("hold1", 0, 0, 4'b0011, 4'b0001, 1'b0);

        // Four back-to-back valids then idle.
        apply_stimulus("b2b0", 0, 1, 4'b0111, 4'b0010, 1'b0);
        apply_stimulus("b2b1", 0, 1, 4'b0001, 4'b0100, 1'b1);
        apply_stimulus("b2b2", 0, 1, 4'b1100, 4'b0101, 1'b0);
        apply_stimulus("b2b3", 0, 1, 4'b1000, 4'b1000, 1'b1);
        apply_stimulus("b2b_idle", 0, 0, 4'b0000, 4'b0000, 1'b0);

        // Reset overrides a valid input, then normal operation resumes.
        apply_stimulus("pre_rst", 0, 1, 4'b1001, 4'b0011, 1'b0);
        in_valid = 1; a = 4'b1111; b = 4'b0000; bin = 0; rst = 1;
        @(posedge clk);
        #1;
        check_output("rst_mid", 0, 4'b0000, 0, 0, 0);
        model_step(1, 1, 4'b1111, 4'b0000, 1'b0);
        apply_stimulus("post_rst", 0, 1, 4'b0100, 4'b0001, 1'b1);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus($sformatf("rand%0d", i), ($urandom_range(0, 29) == 0),
                           $urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                           1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
